expr_vector_sequencer: RTL and testbench
========================================

Name: expr_vector_sequencer

Overview:
- Sequences test vectors through a combinational mixed-signedness expression evaluator: 12 operands a0..a5, b0..b5 in, 90-bit packed result y out.
- Per vector: fetch operands (external stream or internal LFSR), drive the evaluator, wait a programmable settle time, capture y.
- Captured results are compacted into a 32-bit MISR signature and forwarded on a valid/ready result stream.
- Sits between the regression stimulus source and the evaluator instance.

Parameters:
- EVAL_LAT, 1, cycles between registered operand update and dut_y sampling (1..15).
- CNT_W, 16, width of the vector-count and num_vec fields.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a run; ignored while busy.
- abort  in  1  synchronous run cancel.
- gen_mode  in  1  sampled at start: 1 = LFSR stimulus, 0 = external stream.
- num_vec  in  CNT_W  vectors per run, sampled at start.
- seed  in  64  LFSR seed, sampled at start.
- in_valid  in  1  external vector valid.
- in_vec  in  60  external operand vector.
- in_ready  out  1  vector accepted when in_valid & in_ready.
- opnd  out  60  registered operand bus to evaluator.
- dut_y  in  90  evaluator result.
- out_valid  out  1  result valid.
- out_y  out  90  captured result.
- out_ready  in  1  result consumer ready.
- signature  out  32  MISR value.
- vec_count  out  CNT_W  vectors completed this run.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at run completion.

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; opnd, out_y, signature, vec_count = 0; in_ready, out_valid, done, busy = 0; LFSR = 1.
- Operand packing, MSB first: a0[3:0], a1[4:0], a2[5:0], a3[3:0], a4[4:0], a5[5:0], b0..b5 with the same widths. Total 60 bits. a3..a5 and b3..b5 are signed, and the evaluator interprets them that way. The sequencer treats all bits as raw.

FSM states: IDLE, FETCH, SETTLE, CAPTURE, OUT.

- IDLE:
  - On start: latch gen_mode, num_vec, seed; clear signature and vec_count.
  - LFSR = seed, or 1 if seed == 0.
  - If num_vec == 0: pulse done next cycle and stay IDLE. Otherwise go to FETCH.
- FETCH, external mode:
  - in_ready = 1 combinationally in this state only.
  - On a handshake: opnd <= in_vec, go to SETTLE.
- FETCH, gen mode:
  - opnd <= LFSR[59:0], advance LFSR once, go to SETTLE (1 cycle, in_ready stays 0).
  - LFSR is 64-bit Galois, right-shifting, tap mask 64'hD800_0000_0000_0000.
- SETTLE: down-counter loaded with EVAL_LAT-1 on entry. Leave to CAPTURE when it reaches 0, so with EVAL_LAT=1 SETTLE lasts 1 cycle.
- CAPTURE:
  - out_y <= dut_y; vec_count++.
  - signature <= {sig[30:0],0} ^ (sig[31] ? 32'h04C11DB7 : 0) ^ fold.
  - fold = y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]}.
  - Go to OUT.
- OUT:
  - out_valid = 1. out_y is stable while out_valid & !out_ready.
  - On a handshake: if vec_count == num_vec, pulse done and go to IDLE; else go to FETCH.
  - No fetch overlaps a pending result.
- abort (any state except IDLE):
  - Go to IDLE at the next edge; out_valid and in_ready drop.
  - No done pulse; signature and vec_count hold their last values.
  - abort has priority over every handshake in the same cycle.
- start coincident with abort in IDLE: start wins.
- vec_count wraps at 2^CNT_W. This is unreachable because num_vec ≤ 2^CNT_W-1.
- Handshake-to-opnd latency is 1 cycle. With EVAL_LAT=1, the minimum per-vector period is 4 cycles plus out_ready stalls.
- opnd holds its value between vectors and after done.

Decomposition:
- Package expr_seq_pkg:
  - operand width constants (A0_W=4 … B5_W=6, OPND_W=60, Y_W=90);
  - state enum;
  - MISR_POLY = 32'h04C11DB7, LFSR_TAPS;
  - fold function.
- Sub-module expr_seq_lfsr: 64-bit Galois LFSR with load, step and zero-seed substitution.
- FSM, counters and MISR stay in the top module.

Test Plan:
- Single external vector: num_vec=1, EVAL_LAT=1, in_vec=0, dut_y stub 90'h1 → out_y=90'h1, signature=32'h00000001, vec_count=1, done pulse 1 cycle after out handshake.
- Two vectors with dut_y=90'h1 each → signature 32'h00000003, exactly 2 out handshakes, done once.
- Backpressure: out_ready low 5 cycles during OUT → out_valid held, out_y stable, in_ready=0 throughout, no opnd change.
- num_vec=0 start → done one cycle later, busy never asserted, vec_count=0, signature=0.
- Gen mode, seed=0, num_vec=3 → LFSR starts at 1, first opnd=60'h1, three distinct opnd values, in_ready never 1.
- abort asserted in SETTLE of vector 2 of 4 → IDLE next edge, no done, vec_count=1; a following start clears signature and runs fully. Also apply rst_n=0 mid-OUT → all outputs return to their reset values.

Source files
------------

// File: rtl/expr_seq_pkg.sv
// expr_seq_pkg: shared widths, FSM states, polynomials and MISR fold helper for the vector sequencer
package expr_seq_pkg;
  localparam int A0_W = 4;
  localparam int A1_W = 5;
  localparam int A2_W = 6;
  localparam int A3_W = 4;
  localparam int A4_W = 5;
  localparam int A5_W = 6;
  localparam int B0_W = 4;
  localparam int B1_W = 5;
  localparam int B2_W = 6;
  localparam int B3_W = 4;
  localparam int B4_W = 5;
  localparam int B5_W = 6;
  localparam int OPND_W = A0_W + A1_W + A2_W + A3_W + A4_W + A5_W + B0_W + B1_W + B2_W + B3_W + B4_W + B5_W;
  localparam int Y_W = 90;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SETTLE, S_CAPTURE, S_OUT} state_e;
  function automatic logic [31:0] fold(input logic [Y_W-1:0] y);
    return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
  endfunction
endpackage

// File: rtl/expr_seq_lfsr.sv
// expr_seq_lfsr: 64-bit right-shifting Galois LFSR with seed load; a zero seed is replaced by 1
module expr_seq_lfsr import expr_seq_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [63:0]       seed,
  input  logic              step,
  output logic [OPND_W-1:0] value
);
  logic [63:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d = load ? ((seed == '0) ? 64'd1 : seed) : step ? ((lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0)) : lfsr_q;
  end
  always_ff @(posedge clk) begin
    lfsr_q <= !rst_n ? 64'd1 : lfsr_d;
  end
  assign value = lfsr_q[OPND_W-1:0];
endmodule

// File: rtl/expr_vector_sequencer.sv
// expr_vector_sequencer: fetches operand vectors, drives the evaluator, captures y into a MISR and result stream
module expr_vector_sequencer import expr_seq_pkg::*; #(
  parameter int EVAL_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              gen_mode,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [63:0]       seed,
  input  logic              in_valid,
  input  logic [OPND_W-1:0] in_vec,
  output logic              in_ready,
  output logic [OPND_W-1:0] opnd,
  input  logic [Y_W-1:0]    dut_y,
  output logic              out_valid,
  output logic [Y_W-1:0]    out_y,
  input  logic              out_ready,
  output logic [31:0]       signature,
  output logic [CNT_W-1:0]  vec_count,
  output logic              busy,
  output logic              done
);
  localparam logic [3:0] SETTLE_INIT = 4'(EVAL_LAT - 1);
  state_e            state_q, state_d;
  logic              gen_q, gen_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OPND_W-1:0] opnd_q, opnd_d;
  logic [Y_W-1:0]    out_y_q, out_y_d;
  logic [31:0]       sig_q, sig_d;
  logic [3:0]        settle_q, settle_d;
  logic              done_q, done_d;
  logic              lfsr_load, lfsr_step;
  logic [OPND_W-1:0] lfsr_val;
  expr_seq_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step),
    .value (lfsr_val)
  );
  // abort outranks every handshake; in IDLE it is ignored so start wins
  always_comb begin
    state_d   = state_q;
    gen_d     = gen_q;
    num_d     = num_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    out_y_d   = out_y_q;
    sig_d     = sig_q;
    settle_d  = settle_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          gen_d     = gen_mode;
          num_d     = num_vec;
          sig_d     = '0;
          cnt_d     = '0;
          lfsr_load = 1'b1;
          done_d    = num_vec == '0;
          state_d   = (num_vec == '0) ? S_IDLE : S_FETCH;
        end
        S_FETCH: if (gen_q || in_valid) begin
          opnd_d    = gen_q ? lfsr_val : in_vec;
          lfsr_step = gen_q;
          settle_d  = SETTLE_INIT;
          state_d   = S_SETTLE;
        end
        S_SETTLE: begin
          settle_d = settle_q - 1'b1;
          state_d  = (settle_q == '0) ? S_CAPTURE : S_SETTLE;
        end
        S_CAPTURE: begin
          out_y_d = dut_y;
          cnt_d   = cnt_q + 1'b1;
          sig_d   = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : '0) ^ fold(dut_y);
          state_d = S_OUT;
        end
        S_OUT: if (out_ready) begin
          done_d  = cnt_q == num_q;
          state_d = (cnt_q == num_q) ? S_IDLE : S_FETCH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gen_q    <= 1'b0;
      num_q    <= '0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      out_y_q  <= '0;
      sig_q    <= '0;
      settle_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gen_q    <= gen_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      out_y_q  <= out_y_d;
      sig_q    <= sig_d;
      settle_q <= settle_d;
      done_q   <= done_d;
    end
  end
  assign in_ready  = state_q == S_FETCH && !gen_q;
  assign out_valid = state_q == S_OUT;
  assign busy      = state_q != S_IDLE;
  assign done      = done_q;
  assign opnd      = opnd_q;
  assign out_y     = out_y_q;
  assign signature = sig_q;
  assign vec_count = cnt_q;
endmodule

// File: tb/tb_expr_vector_sequencer.sv
// tb_expr_vector_sequencer: table-driven runs, hand-written corner sequences and randomized scoreboard runs
module tb_expr_vector_sequencer;
  localparam int CNT_W = 16;
  logic              clk = 1'b0;
  logic              rst_n, start, abort, gen_mode, in_valid, out_ready;
  logic [CNT_W-1:0]  num_vec;
  logic [63:0]       seed;
  logic [59:0]       in_vec;
  logic              in_ready, out_valid, busy, done;
  logic [59:0]       opnd;
  logic [89:0]       dut_y, out_y, stub_y;
  logic [31:0]       signature;
  logic [CNT_W-1:0]  vec_count;
  logic              use_stub;
  int total = 0;
  int bad = 0;
  typedef struct {
    int          n;
    logic [89:0] y;
    logic [31:0] sig;
  } vec_t;
  vec_t tbl[8];

  expr_vector_sequencer #(.EVAL_LAT(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gen_mode(gen_mode),
    .num_vec(num_vec), .seed(seed), .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready),
    .opnd(opnd), .dut_y(dut_y), .out_valid(out_valid), .out_y(out_y), .out_ready(out_ready),
    .signature(signature), .vec_count(vec_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // stand-in evaluator: any fixed function of the operand bus exercises every y bit
  function automatic logic [89:0] evaluator(input logic [59:0] v);
    return {v[29:0], v ^ 60'hF0F_0F0F_0F0F_0F0F};
  endfunction
  assign dut_y = use_stub ? stub_y : evaluator(opnd);

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [89:0] y);
    logic [31:0] f;
    f = y[31:0] ^ y[63:32] ^ 32'(y[89:64]);
    return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C1_1DB7 : 32'h0) ^ f;
  endfunction

  task automatic chk(input string name, input logic [89:0] act, input logic [89:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_fixed(input int n, input logic [89:0] y, input logic [31:0] exp_sig, input bit with_abort);
    int hs = 0;
    int cyc = 0;
    int last_hs = 0;
    use_stub = 1'b1; stub_y = y; gen_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_vec = '0;
    start = 1'b1; abort = with_abort; num_vec = CNT_W'(n);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("fx_busy", 90'(busy), 90'd1);
    while (!done && cyc < 200) begin
      if (out_valid) begin hs++; last_hs = cyc; end
      @(negedge clk);
      cyc++;
    end
    chk("fx_done", 90'(done), 90'd1);
    chk("fx_done_lat", 90'(cyc - last_hs), 90'd1);
    chk("fx_handshakes", 90'(hs), 90'(n));
    chk("fx_sig", 90'(signature), 90'(exp_sig));
    chk("fx_cnt", 90'(vec_count), 90'(n));
    chk("fx_out_y", out_y, y);
    chk("fx_idle", 90'(busy), 90'd0);
    @(negedge clk);
    chk("fx_done_pulse", 90'(done), 90'd0);
  endtask

  task automatic run_random(input bit gm, input int n, input logic [63:0] sd);
    logic [63:0] l;
    logic [31:0] sig;
    logic [59:0] vq[$];
    logic [59:0] v, prev;
    logic [89:0] ey;
    int got = 0;
    int cyc = 0;
    bit saw_ready = 1'b0;
    l = (sd == 64'd0) ? 64'd1 : sd;
    sig = '0;
    prev = '0;
    use_stub = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    start = 1'b1; gen_mode = gm; num_vec = CNT_W'(n); seed = sd;
    @(negedge clk);
    start = 1'b0;
    while (got < n && cyc < 3000) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_vec = 60'({$urandom, $urandom});
      out_ready = $urandom_range(0, 2) != 0;
      if (in_ready) saw_ready = 1'b1;
      if (in_ready && in_valid) vq.push_back(in_vec);
      if (out_valid && out_ready) begin
        if (gm) begin
          v = l[59:0];
          l = lfsr_next(l);
        end else begin
          v = (vq.size() > 0) ? vq.pop_front() : 60'h0;
        end
        ey = evaluator(v);
        sig = misr(sig, ey);
        got++;
        chk("rnd_opnd", 90'(opnd), 90'(v));
        chk("rnd_out_y", out_y, ey);
        chk("rnd_cnt", 90'(vec_count), 90'(got));
        if (gm && got > 1) chk("rnd_distinct", 90'(opnd != prev), 90'd1);
        prev = opnd;
      end
      @(negedge clk);
      cyc++;
    end
    chk("rnd_complete", 90'(got), 90'(n));
    chk("rnd_done", 90'(done), 90'd1);
    chk("rnd_sig", 90'(signature), 90'(sig));
    chk("rnd_idle", 90'(busy), 90'd0);
    if (gm) chk("rnd_gen_no_ready", 90'(saw_ready), 90'd0);
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, lat;
    logic [89:0] y_snap;
    logic [59:0] op_snap;
    tbl[0] = '{1, 90'h1, 32'h0000_0001};
    tbl[1] = '{2, 90'h1, 32'h0000_0003};
    tbl[2] = '{3, 90'h1, 32'h0000_0007};
    tbl[3] = '{1, 90'h1_0000_0000, 32'h0000_0001};
    tbl[4] = '{1, 90'h200_0000_0000_0000_0000_0000, 32'h0200_0000};
    tbl[5] = '{2, 90'h3_0000_0003, 32'h0000_0000};
    tbl[6] = '{1, {90{1'b1}}, 32'h03FF_FFFF};
    tbl[7] = '{2, 90'h8000_0000, 32'h84C1_1DB7};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; gen_mode = 1'b0; num_vec = '0; seed = '0;
    in_valid = 1'b0; in_vec = '0; out_ready = 1'b0; use_stub = 1'b1; stub_y = '0;
    repeat (2) @(negedge clk);
    chk("rst_opnd", 90'(opnd), 90'd0);
    chk("rst_out_y", out_y, 90'd0);
    chk("rst_sig", 90'(signature), 90'd0);
    chk("rst_cnt", 90'(vec_count), 90'd0);
    chk("rst_flags", 90'({in_ready, out_valid, done, busy}), 90'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_fixed(tbl[i].n, tbl[i].y, tbl[i].sig, 1'b0);
    // zero-length run: done only, never busy, counters cleared
    start = 1'b1; num_vec = '0; gen_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("nv0_done", 90'(done), 90'd1);
    chk("nv0_busy", 90'(busy), 90'd0);
    chk("nv0_sig", 90'(signature), 90'd0);
    chk("nv0_cnt", 90'(vec_count), 90'd0);
    @(negedge clk);
    chk("nv0_done_pulse", 90'(done), 90'd0);
    chk("nv0_busy2", 90'(busy), 90'd0);
    // backpressure on the result stream
    stub_y = 90'hABC; in_vec = 60'h123_4567_89AB_CDEF; in_valid = 1'b1; out_ready = 1'b0;
    start = 1'b1; num_vec = CNT_W'(1);
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    chk("bp_latency", 90'(lat), 90'd4);
    chk("bp_opnd", 90'(opnd), 90'(60'h123_4567_89AB_CDEF));
    chk("bp_out_y", out_y, 90'hABC);
    y_snap = out_y; op_snap = opnd; in_vec = 60'hFED_CBA9_8765_4321; stub_y = 90'h555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held", 90'(out_valid), 90'd1);
      chk("bp_y_stable", out_y, y_snap);
      chk("bp_no_ready", 90'(in_ready), 90'd0);
      chk("bp_opnd_stable", 90'(opnd), 90'(op_snap));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", 90'(done), 90'd1);
    chk("bp_cnt", 90'(vec_count), 90'd1);
    @(negedge clk);
    // gen mode from a zero seed: LFSR must start at 1
    run_random(1'b1, 3, 64'd0);
    // abort in SETTLE of vector 2 of 4
    stub_y = 90'h1; in_valid = 1'b1; out_ready = 1'b1; gen_mode = 1'b0; use_stub = 1'b1;
    start = 1'b1; num_vec = CNT_W'(4);
    @(negedge clk);
    start = 1'b0; cyc = 0;
    while (!(in_ready && vec_count == CNT_W'(1)) && cyc < 50) begin @(negedge clk); cyc++; end
    chk("ab_reach_fetch2", 90'(cyc < 50), 90'd1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", 90'(busy), 90'd0);
    chk("ab_flags", 90'({out_valid, in_ready, done}), 90'd0);
    chk("ab_cnt", 90'(vec_count), 90'd1);
    chk("ab_sig", 90'(signature), 90'd1);
    @(negedge clk);
    chk("ab_no_done", 90'(done), 90'd0);
    run_fixed(2, 90'h1, 32'h0000_0003, 1'b1);
    // randomized scoreboard runs
    for (int r = 0; r < 3; r++) run_random(1'b0, $urandom_range(4, 12), 64'd0);
    for (int r = 0; r < 3; r++) run_random(1'b1, $urandom_range(4, 12), {$urandom, $urandom});
    // reset while a result is pending
    use_stub = 1'b1; stub_y = 90'h3_0000_0001; in_valid = 1'b1; out_ready = 1'b0; gen_mode = 1'b0;
    start = 1'b1; num_vec = CNT_W'(2);
    @(negedge clk);
    start = 1'b0; cyc = 0;
    while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
    chk("rm_in_out", 90'(out_valid), 90'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm_opnd", 90'(opnd), 90'd0);
    chk("rm_out_y", out_y, 90'd0);
    chk("rm_sig", 90'(signature), 90'd0);
    chk("rm_cnt", 90'(vec_count), 90'd0);
    chk("rm_flags", 90'({in_ready, out_valid, done, busy}), 90'd0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
